alu_writeback_pipe: RTL and testbench

Two-stage execute/write-back pipeline that sits directly in front of `nbit_register_file`. It accepts one register-register instruction per cycle under a valid/ready handshake and drives the register file's read selects. It computes the ALU result, with forwarding from its own pending write-back, and drives the register file's write port one cycle later. A multiply op runs iteratively and stalls issue while it is busy.

---
 rtl/alu_pipe_pkg.sv | 21 ++
 rtl/iterative_multiplier.sv | 71 +++++++
 rtl/alu_writeback_pipe.sv | 136 +++++++++++++
 tb/tb_alu_writeback_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the execute/write-back pipeline: opcodes, FSM state
// type and the retire counter width.
package alu_pipe_pkg;

  localparam int RETIRE_W = 16;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/iterative_multiplier.sv
// Radix-2 shift-add multiplier producing the low data_width bits of the
// product. A start pulse latches the operands; done_o is high during the
// final of data_width iteration cycles, and product_o carries the finished
// result during that cycle.
module iterative_multiplier #(
  parameter int data_width = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [data_width-1:0] op_a_i,
  input  logic [data_width-1:0] op_b_i,
  output logic                  done_o,
  output logic [data_width-1:0] product_o
);

  localparam int CNT_W = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(data_width - 1);

  logic [data_width-1:0] mcand_q, mcand_d;
  logic [data_width-1:0] mplier_q, mplier_d;
  logic [data_width-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  active_q, active_d;
  logic [data_width-1:0] acc_sum_s;

  // Next-state for the shift-add datapath and iteration counter.
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o    = active_q && (cnt_q == LAST_CNT);
    product_o = acc_sum_s;
    if (start_i) begin
      mcand_d  = op_a_i;
      mplier_d = op_b_i;
      acc_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d    = acc_sum_s;
      mcand_d  = {mcand_q[data_width-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[data_width-1:1]};
      cnt_d    = cnt_q + 1'b1;
      active_d = !done_o;
    end else begin
      active_d = 1'b0;
    end
  end

  // Datapath registers; reset clears the accumulator and aborts any run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_writeback_pipe.sv
// Two-stage execute/write-back pipeline in front of the register file:
// operand forwarding from the pending write-back, single-cycle ALU, an
// iterative multiply that stalls issue, the WB register and retire counter.
module alu_writeback_pipe
  import alu_pipe_pkg::*;
#(
  parameter int data_width   = 32,
  parameter int select_width = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    InstrValid,
  output logic                    InstrReady,
  input  logic [2:0]              Opcode,
  input  logic [select_width-1:0] Rs,
  input  logic [select_width-1:0] Rt,
  input  logic [select_width-1:0] Rd,
  output logic [select_width-1:0] ReadSelect1,
  output logic [select_width-1:0] ReadSelect2,
  input  logic [data_width-1:0]   ReadData1,
  input  logic [data_width-1:0]   ReadData2,
  output logic [data_width-1:0]   WriteData,
  output logic [select_width-1:0] WriteSelect,
  output logic                    WriteEnable,
  output logic                    Busy,
  output logic [RETIRE_W-1:0]     RetireCount
);

  state_e                  state_q, state_d;
  logic [data_width-1:0]   wd_q, wd_d;
  logic [select_width-1:0] ws_q, ws_d;
  logic                    we_q, we_d;
  logic [RETIRE_W-1:0]     rc_q, rc_d;
  logic [select_width-1:0] mul_rd_q, mul_rd_d;

  logic [data_width-1:0]   op_a_s, op_b_s, alu_result_s, mul_product_s;
  logic                    accept_s, mul_start_s, mul_done_s;

  assign ReadSelect1 = Rs;
  assign ReadSelect2 = Rt;
  assign InstrReady  = (state_q == ST_IDLE);
  assign Busy        = (state_q == ST_MUL);
  assign WriteData   = wd_q;
  assign WriteSelect = ws_q;
  assign WriteEnable = we_q;
  assign RetireCount = rc_q;

  assign accept_s    = InstrValid && (state_q == ST_IDLE);
  assign mul_start_s = accept_s && (Opcode == OP_MUL);

  // Forwarding muxes and ALU; r0 never forwards since we_q is never set for it.
  always_comb begin
    op_a_s       = (we_q && (ws_q == Rs)) ? wd_q : ReadData1;
    op_b_s       = (we_q && (ws_q == Rt)) ? wd_q : ReadData2;
    alu_result_s = '0;
    case (Opcode)
      OP_ADD:  alu_result_s = op_a_s + op_b_s;
      OP_SUB:  alu_result_s = op_a_s - op_b_s;
      OP_AND:  alu_result_s = op_a_s & op_b_s;
      OP_OR:   alu_result_s = op_a_s | op_b_s;
      OP_XOR:  alu_result_s = op_a_s ^ op_b_s;
      OP_SLT:  alu_result_s = {{(data_width-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
      OP_SLL:  alu_result_s = op_a_s << op_b_s[4:0];
      default: alu_result_s = '0;
    endcase
  end

  iterative_multiplier #(
    .data_width(data_width)
  ) u_mul (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .start_i  (mul_start_s),
    .op_a_i   (op_a_s),
    .op_b_i   (op_b_s),
    .done_o   (mul_done_s),
    .product_o(mul_product_s)
  );

  // FSM next state and WB register load; WriteEnable drops on any edge without a result.
  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    ws_d     = ws_q;
    we_d     = 1'b0;
    rc_d     = rc_q;
    mul_rd_d = mul_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (Opcode == OP_MUL)) begin
          mul_rd_d = Rd;
          state_d  = ST_MUL;
        end else if (accept_s) begin
          wd_d = alu_result_s;
          ws_d = Rd;
          we_d = (Rd != '0);
          rc_d = rc_q + 16'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          wd_d    = mul_product_s;
          ws_d    = mul_rd_q;
          we_d    = (mul_rd_q != '0);
          rc_d    = rc_q + 16'd1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, WB register and retire counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      wd_q     <= '0;
      ws_q     <= '0;
      we_q     <= 1'b0;
      rc_q     <= '0;
      mul_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      ws_q     <= ws_d;
      we_q     <= we_d;
      rc_q     <= rc_d;
      mul_rd_q <= mul_rd_d;
    end
  end

endmodule

// File: tb/tb_alu_writeback_pipe.sv
// Scoreboard bench for alu_writeback_pipe with a behavioural register file
// initialised to rN = 10*N. Expected write-backs are queued at issue and
// popped by a monitor on each falling edge where WriteEnable is high.
module tb_alu_writeback_pipe;
  import alu_pipe_pkg::*;

  localparam int DW = 32;
  localparam int SW = 5;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          InstrValid;
  logic          InstrReady;
  logic [2:0]    Opcode;
  logic [SW-1:0] Rs, Rt, Rd;
  logic [SW-1:0] ReadSelect1, ReadSelect2;
  logic [DW-1:0] ReadData1, ReadData2;
  logic [DW-1:0] WriteData;
  logic [SW-1:0] WriteSelect;
  logic          WriteEnable;
  logic          Busy;
  logic [15:0]   RetireCount;

  logic [DW-1:0] rf [32];
  logic [36:0]   exp_q [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            stalls;

  alu_writeback_pipe #(.data_width(DW), .select_width(SW)) dut (
    .Clk(Clk), .Reset(Reset), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .ReadSelect1(ReadSelect1), .ReadSelect2(ReadSelect2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteData(WriteData), .WriteSelect(WriteSelect), .WriteEnable(WriteEnable),
    .Busy(Busy), .RetireCount(RetireCount)
  );

  always #5 Clk = ~Clk;

  assign ReadData1 = rf[ReadSelect1];
  assign ReadData2 = rf[ReadSelect2];

  // Behavioural register file: r0 hard-wired to zero.
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(10 * i);
    forever begin
      @(posedge Clk);
      if (WriteEnable && (WriteSelect != 5'd0)) rf[WriteSelect] <= WriteData;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [36:0] e;
    forever begin
      @(negedge Clk);
      if (!Reset && WriteEnable) begin
        if (exp_q.size() == 0) begin
          check("unexpected write", 32'(WriteSelect), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wb select", 32'(WriteSelect), 32'(e[36:32]));
          check("wb data", WriteData, e[31:0]);
        end
      end
    end
  endtask

  // Presents one instruction, waits (bounded) for acceptance, returns at accept edge + 1.
  task automatic issue(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] exp, input bit expect_wb,
                       output int n_stall);
    Opcode = op; Rs = rs; Rt = rt; Rd = rd; InstrValid = 1'b1;
    if (expect_wb) exp_q.push_back({rd, exp});
    n_stall = 0;
    forever begin
      @(negedge Clk);
      if (InstrReady) break;
      n_stall++;
      if (n_stall > 100) begin
        check("accept timeout", 32'(n_stall), 32'd0);
        break;
      end
    end
    @(posedge Clk);
    #1;
    InstrValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    fork
      monitor();
    join_none
    Reset = 1'b1; InstrValid = 1'b0; Opcode = OP_ADD; Rs = '0; Rt = '0; Rd = '0;
    #1;
    check("reset WriteEnable", 32'(WriteEnable), 32'd0);
    check("reset WriteData", WriteData, 32'd0);
    check("reset WriteSelect", 32'(WriteSelect), 32'd0);
    check("reset RetireCount", 32'(RetireCount), 32'd0);
    check("reset Busy", 32'(Busy), 32'd0);
    check("reset InstrReady", 32'(InstrReady), 32'd1);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    idle(1);

    // ADD r3 <- r1 + r2 : WB visible one cycle after accept
    issue(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd30, 1'b1, stalls);
    check("add WriteEnable", 32'(WriteEnable), 32'd1);
    check("add WriteSelect", 32'(WriteSelect), 32'd3);
    check("add WriteData", WriteData, 32'd30);
    idle(2);
    check("r3 after add", rf[3], 32'd30);
    check("retire after add", 32'(RetireCount), 32'd1);

    // Back-to-back hazard: SUB must see forwarded r4=30, not stale 40
    issue(OP_ADD, 5'd1, 5'd2, 5'd4, 32'd30, 1'b1, stalls);
    issue(OP_SUB, 5'd4, 5'd1, 5'd5, 32'd20, 1'b1, stalls);
    check("no bubble b2b", 32'(stalls), 32'd0);
    idle(2);

    // SUB negative, forwarded signed SLT, SLL, logic ops
    issue(OP_SUB, 5'd1, 5'd2, 5'd7, 32'hFFFF_FFF6, 1'b1, stalls);
    issue(OP_SLT, 5'd7, 5'd1, 5'd8, 32'd1, 1'b1, stalls);
    issue(OP_SLL, 5'd1, 5'd2, 5'd9, 32'h00A0_0000, 1'b1, stalls);
    issue(OP_AND, 5'd3, 5'd5, 5'd10, 32'd20, 1'b1, stalls);
    issue(OP_OR,  5'd3, 5'd5, 5'd11, 32'd30, 1'b1, stalls);
    issue(OP_XOR, 5'd3, 5'd5, 5'd12, 32'd10, 1'b1, stalls);
    issue(OP_SLT, 5'd1, 5'd7, 5'd15, 32'd0, 1'b1, stalls);

    // MUL r6 <- r2*r3 followed by an ADD held valid that forwards the product
    issue(OP_MUL, 5'd2, 5'd3, 5'd6, 32'd600, 1'b1, stalls);
    check("busy after mul accept", 32'(Busy), 32'd1);
    check("ready low after mul accept", 32'(InstrReady), 32'd0);
    issue(OP_ADD, 5'd6, 5'd1, 5'd13, 32'd610, 1'b1, stalls);
    check("mul stall cycles", 32'(stalls), 32'd32);
    idle(2);
    check("r6 after mul", rf[6], 32'd600);
    check("r13 after fwd add", rf[13], 32'd610);
    check("r8 slt", rf[8], 32'd1);
    check("r9 sll", rf[9], 32'h00A0_0000);
    check("retire after mul", 32'(RetireCount), 32'd12);

    // Write to r0 is suppressed but still retires
    issue(OP_ADD, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0, stalls);
    check("r0 WriteEnable", 32'(WriteEnable), 32'd0);
    check("retire after r0 add", 32'(RetireCount), 32'd13);
    idle(1);
    issue(OP_ADD, 5'd0, 5'd0, 5'd1, 32'd0, 1'b1, stalls);
    issue(OP_ADD, 5'd2, 5'd3, 5'd14, 32'd50, 1'b1, stalls);
    idle(2);
    check("r0 stays zero", rf[0], 32'd0);
    check("r1 from r0+r0", rf[1], 32'd0);
    check("retire before reset", 32'(RetireCount), 32'd15);
    check("queue drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a MUL: aborted, no write, count cleared
    issue(OP_MUL, 5'd2, 5'd2, 5'd6, 32'd400, 1'b0, stalls);
    idle(9);
    Reset = 1'b1;
    #1;
    check("midreset WriteEnable", 32'(WriteEnable), 32'd0);
    check("midreset WriteData", WriteData, 32'd0);
    check("midreset WriteSelect", 32'(WriteSelect), 32'd0);
    check("midreset RetireCount", 32'(RetireCount), 32'd0);
    check("midreset Busy", 32'(Busy), 32'd0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    idle(40);
    check("post reset InstrReady", 32'(InstrReady), 32'd1);
    check("post reset RetireCount", 32'(RetireCount), 32'd0);
    check("post reset Busy", 32'(Busy), 32'd0);
    check("r6 untouched by aborted mul", rf[6], 32'd600);
    check("queue empty at end", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
